// File: rtl/eq_seq_cmp_amisha_if.sv
// Handshake/operand/result bundle for eq_seq_cmp_amisha.
// master drives start and operands; slave (the comparator) drives status and results.
interface eq_seq_cmp_amisha_if #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  logic             start_amisha;
  logic [WIDTH-1:0] a_amisha;
  logic [WIDTH-1:0] b_amisha;
  logic             busy_amisha;
  logic             done_amisha;
  logic             eq_amisha;
  logic             gt_amisha;
  logic             lt_amisha;
  logic [CW-1:0]    mm_cnt_amisha;

  modport master (
    output start_amisha, a_amisha, b_amisha,
    input  busy_amisha, done_amisha, eq_amisha, gt_amisha, lt_amisha, mm_cnt_amisha
  );

  modport slave (
    input  start_amisha, a_amisha, b_amisha,
    output busy_amisha, done_amisha, eq_amisha, gt_amisha, lt_amisha, mm_cnt_amisha
  );
endinterface

// File: rtl/eq_seq_cmp_amisha.sv
// Sequential WIDTH-bit unsigned comparator, CHUNK bits per cycle, MSB chunk first.
// Optional macro EQ_SEQ_CMP_EARLY_EXIT_EN: stop at the first differing chunk.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands latched on acceptance
// RUN   | one chunk compared per cycle, busy high
// DONE  | results registered on entry, done high for one cycle
module eq_seq_cmp_amisha #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic               clk_amisha,
  input logic               reset_amisha,
  eq_seq_cmp_amisha_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int RW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, a_sh_nxt, b_sh, b_sh_nxt;
  logic [RW-1:0]    rem, rem_nxt;
  logic             decided, decided_nxt;
  logic             gt_int, gt_int_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             eq, eq_nxt, gt, gt_nxt, lt, lt_nxt;
  logic [CW-1:0]    mm_cnt, mm_cnt_nxt;
  logic [CHUNK-1:0] a_top, b_top;
  logic             differ, last, finish;

  // Shadows shift left each RUN cycle, so the chunk under test is always the top one.
  assign a_top  = a_sh[WIDTH-1 -: CHUNK];
  assign b_top  = b_sh[WIDTH-1 -: CHUNK];
  assign differ = (a_top != b_top);
  assign last   = (rem == '0);

`ifdef EQ_SEQ_CMP_EARLY_EXIT_EN
  assign finish = last | differ;
`else
  assign finish = last;
`endif

  assign bus.busy_amisha   = (state == RUN);
  assign bus.done_amisha   = (state == DONE);
  assign bus.eq_amisha     = eq;
  assign bus.gt_amisha     = gt;
  assign bus.lt_amisha     = lt;
  assign bus.mm_cnt_amisha = mm_cnt;

  // State, shadow operands, chunk countdown and registered results.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      rem     <= '0;
      decided <= 1'b0;
      gt_int  <= 1'b0;
      cnt     <= '0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      mm_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      a_sh    <= a_sh_nxt;
      b_sh    <= b_sh_nxt;
      rem     <= rem_nxt;
      decided <= decided_nxt;
      gt_int  <= gt_int_nxt;
      cnt     <= cnt_nxt;
      eq      <= eq_nxt;
      gt      <= gt_nxt;
      lt      <= lt_nxt;
      mm_cnt  <= mm_cnt_nxt;
    end
  end

  // Next-state and datapath update; results only change on the RUN->DONE edge.
  always_comb begin
    state_nxt   = state;
    a_sh_nxt    = a_sh;
    b_sh_nxt    = b_sh;
    rem_nxt     = rem;
    decided_nxt = decided;
    gt_int_nxt  = gt_int;
    cnt_nxt     = cnt;
    eq_nxt      = eq;
    gt_nxt      = gt;
    lt_nxt      = lt;
    mm_cnt_nxt  = mm_cnt;
    unique case (state)
      IDLE: begin
        if (bus.start_amisha) begin
          a_sh_nxt    = bus.a_amisha;
          b_sh_nxt    = bus.b_amisha;
          rem_nxt     = RW'(NCHUNK - 1);
          decided_nxt = 1'b0;
          gt_int_nxt  = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        a_sh_nxt = a_sh << CHUNK;
        b_sh_nxt = b_sh << CHUNK;
        if (differ) begin
          cnt_nxt = cnt + CW'(1);
          // Only the most significant differing chunk decides the ordering.
          if (!decided) begin
            decided_nxt = 1'b1;
            gt_int_nxt  = (a_top > b_top);
          end
        end
        if (finish) begin
          state_nxt  = DONE;
          eq_nxt     = ~decided_nxt;
          gt_nxt     = decided_nxt & gt_int_nxt;
          lt_nxt     = decided_nxt & ~gt_int_nxt;
          mm_cnt_nxt = cnt_nxt;
        end else begin
          rem_nxt = rem - RW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
endmodule
